audio_pwm_dac: RTL and testbench

Stereo audio DAC back end for boards without an analogue codec. Consumes the same 16-bit signed stereo samples that feed the HDMI audio path (one pair per 48 kHz strobe derived from `clk_pixel`), buffers them in a small FIFO, and drives `pwm_left`/`pwm_right` as fixed-carrier PWM bitstreams for an external RC filter. Sits beside the HDMI transmitter, downstream of the tone/sample generator, entirely in the `clk_pixel` domain.

---
 rtl/audio_pkg.sv | 19 +
 rtl/audio_sample_fifo.sv | 54 +++++
 rtl/audio_pwm_dac.sv | 133 +++++++++++++
 tb/tb_audio_pwm_dac.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types and helpers for the audio back end.
//   AUDIO_RATE      - nominal sample strobe rate in Hz
//   stereo_sample_t - one signed 16-bit left/right pair
//   offset_binary() - two's complement to offset binary (MSB flip)
package audio_pkg;

    localparam int unsigned AUDIO_RATE   = 48000;
    localparam int unsigned SAMPLE_WIDTH = 16;

    typedef struct packed {
        logic signed [SAMPLE_WIDTH-1:0] left;
        logic signed [SAMPLE_WIDTH-1:0] right;
    } stereo_sample_t;

    function automatic logic [SAMPLE_WIDTH-1:0] offset_binary(input logic [SAMPLE_WIDTH-1:0] s);
        return {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO for stereo sample pairs, single clock domain.
// Ports:
//   clk_pixel, reset (sync, active-high)
//   push/din  - write when push && !full
//   pop/dout  - dout shows the head entry; pop advances when !empty
//   full/empty - derived from pointers one bit wider than the address
module audio_sample_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    // Extra pointer bit distinguishes full (wrapped once) from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; contents are only visible through valid pointers.
    always_ff @(posedge clk_pixel) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/audio_pwm_dac.sv
// Stereo PWM audio DAC back end in the clk_pixel domain.
// Buffers signed stereo pairs in a small FIFO, pops one pair per carrier
// period into sample-and-hold registers and drives registered PWM bitstreams.
// Ports:
//   clk_pixel, reset (sync, active-high)
//   sample_valid/sample_ready, sample_left/sample_right - sample push side
//   pwm_left/pwm_right - registered 1-bit outputs for an external RC filter
//   overrun            - sticky, set when a pair arrives while the FIFO is full
// Build option: define AUDIO_PWM_SIGMA_DELTA_EN to replace the PWM comparator
// with a first-order sigma-delta modulator per channel.
module audio_pwm_dac
    import audio_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 16,
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ATTEN_SHIFT = 0
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic [BIT_WIDTH-1:0] sample_left,
    input  logic [BIT_WIDTH-1:0] sample_right,
    output logic                 pwm_left,
    output logic                 pwm_right,
    output logic                 overrun
);

    localparam logic [PWM_BITS-1:0] PcntMax = '1;

    logic [PWM_BITS-1:0]         pcnt_q;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        push;
    logic                        pop;
    logic [2*BIT_WIDTH-1:0]      fifo_dout;
    logic signed [BIT_WIDTH-1:0] held_left_q;
    logic signed [BIT_WIDTH-1:0] held_right_q;
    logic signed [BIT_WIDTH-1:0] s_left;
    logic signed [BIT_WIDTH-1:0] s_right;
    logic [BIT_WIDTH-1:0]        off_left;
    logic [BIT_WIDTH-1:0]        off_right;
    logic                        overrun_q;

    assign sample_ready = !fifo_full;
    assign push         = sample_valid && !fifo_full;
    // Empty is registered state, so a same-cycle push is never bypassed to the pop.
    assign pop          = (pcnt_q == PcntMax) && !fifo_empty;
    assign overrun      = overrun_q;

    audio_sample_fifo #(
        .WIDTH (2 * BIT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       ({sample_left, sample_right}),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            pcnt_q       <= '0;
            held_left_q  <= '0;
            held_right_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
            if (pop) begin
                {held_left_q, held_right_q} <= fifo_dout;
            end
            if (sample_valid && fifo_full) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Attenuate, then flip the sign bit to get an unsigned offset-binary level.
    assign s_left    = held_left_q >>> ATTEN_SHIFT;
    assign s_right   = held_right_q >>> ATTEN_SHIFT;
    assign off_left  = {~s_left[BIT_WIDTH-1], s_left[BIT_WIDTH-2:0]};
    assign off_right = {~s_right[BIT_WIDTH-1], s_right[BIT_WIDTH-2:0]};

`ifdef AUDIO_PWM_SIGMA_DELTA_EN
    // The accumulator MSB is the carry out of the previous add and is the output.
    logic [BIT_WIDTH:0] acc_left_q;
    logic [BIT_WIDTH:0] acc_right_q;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            acc_left_q  <= '0;
            acc_right_q <= '0;
        end else begin
            acc_left_q  <= {1'b0, acc_left_q[BIT_WIDTH-1:0]} + {1'b0, off_left};
            acc_right_q <= {1'b0, acc_right_q[BIT_WIDTH-1:0]} + {1'b0, off_right};
        end
    end

    assign pwm_left  = acc_left_q[BIT_WIDTH];
    assign pwm_right = acc_right_q[BIT_WIDTH];
`else
    logic [PWM_BITS-1:0] duty_left;
    logic [PWM_BITS-1:0] duty_right;
    logic                pwm_left_q;
    logic                pwm_right_q;
    logic                unused_low_bits;

    // Truncate to the top PWM_BITS of the offset-binary level.
    assign duty_left       = off_left[BIT_WIDTH-1 -: PWM_BITS];
    assign duty_right      = off_right[BIT_WIDTH-1 -: PWM_BITS];
    assign unused_low_bits = ^{off_left[BIT_WIDTH-PWM_BITS-1:0],
                               off_right[BIT_WIDTH-PWM_BITS-1:0]};

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            pwm_left_q  <= 1'b0;
            pwm_right_q <= 1'b0;
        end else begin
            pwm_left_q  <= (pcnt_q < duty_left);
            pwm_right_q <= (pcnt_q < duty_right);
        end
    end

    assign pwm_left  = pwm_left_q;
    assign pwm_right = pwm_right_q;
`endif

endmodule

// File: tb/tb_audio_pwm_dac.sv
module tb_audio_pwm_dac;

    localparam int BW     = 16;
    localparam int PB     = 8;
    localparam int DEPTH  = 4;
    localparam int PERIOD = 1 << PB;

    logic        clk_pixel = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_left = '0;
    logic [15:0] sample_right = '0;
    logic        sample_ready, pwm_left, pwm_right, overrun;
    logic        sample_ready2, pwm_left2, pwm_right2, overrun2;

    always #5 clk_pixel = ~clk_pixel;

    audio_pwm_dac #(
        .BIT_WIDTH(BW), .PWM_BITS(PB), .FIFO_DEPTH(DEPTH), .ATTEN_SHIFT(0)
    ) dut (
        .clk_pixel(clk_pixel), .reset(reset), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sample_left(sample_left), .sample_right(sample_right),
        .pwm_left(pwm_left), .pwm_right(pwm_right), .overrun(overrun)
    );

    audio_pwm_dac #(
        .BIT_WIDTH(BW), .PWM_BITS(PB), .FIFO_DEPTH(DEPTH), .ATTEN_SHIFT(4)
    ) dut_atten (
        .clk_pixel(clk_pixel), .reset(reset), .sample_valid(sample_valid),
        .sample_ready(sample_ready2), .sample_left(sample_left), .sample_right(sample_right),
        .pwm_left(pwm_left2), .pwm_right(pwm_right2), .overrun(overrun2)
    );

    int checks = 0;
    int failures = 0;

    // Behavioural model: queue of pairs, held pair, carrier position.
    int q_l[$];
    int q_r[$];
    int held_l, held_r, pcnt;
    bit m_valid = 0;
    bit e_l, e_r, e_l2, e_r2, e_ovr;
    longint acc[4];

    bit count_en = 0;
    int cnt_l, cnt_r, cnt_l2, cnt_r2;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Level in 0..65535 after attenuation; floor division models >>>.
    function automatic int level_of(int s, int shift);
        int a;
        a = s >>> shift;
        return a + 32768;
    endfunction

    function automatic int duty_of(int s, int shift);
        return level_of(s, shift) / (1 << (BW - PB));
    endfunction

    function automatic bit sd_bit(int idx, int s, int shift);
        acc[idx] = (acc[idx] % 65536) + level_of(s, shift);
        return acc[idx] >= 65536;
    endfunction

    task automatic model_edge(bit rst, bit v, int l, int r);
        bit full;
        if (rst) begin
            q_l.delete();
            q_r.delete();
            held_l = 0; held_r = 0; pcnt = 0;
            e_l = 0; e_r = 0; e_l2 = 0; e_r2 = 0; e_ovr = 0;
            for (int i = 0; i < 4; i++) acc[i] = 0;
            return;
        end
`ifdef AUDIO_PWM_SIGMA_DELTA_EN
        e_l  = sd_bit(0, held_l, 0);
        e_r  = sd_bit(1, held_r, 0);
        e_l2 = sd_bit(2, held_l, 4);
        e_r2 = sd_bit(3, held_r, 4);
`else
        e_l  = pcnt < duty_of(held_l, 0);
        e_r  = pcnt < duty_of(held_r, 0);
        e_l2 = pcnt < duty_of(held_l, 4);
        e_r2 = pcnt < duty_of(held_r, 4);
`endif
        full = (q_l.size() == DEPTH);
        if (pcnt == PERIOD - 1 && q_l.size() > 0) begin
            held_l = q_l.pop_front();
            held_r = q_r.pop_front();
        end
        if (v) begin
            if (!full) begin
                q_l.push_back(l);
                q_r.push_back(r);
            end else begin
                e_ovr = 1;
            end
        end
        pcnt = (pcnt + 1) % PERIOD;
    endtask

    // One clock: compare at negedge, drive inputs, advance model at posedge.
    task automatic step(bit rst, bit v, logic [15:0] l, logic [15:0] r);
        @(negedge clk_pixel);
        if (m_valid) begin
            check("sample_ready", {31'b0, sample_ready}, {31'b0, q_l.size() < DEPTH});
            check("overrun", {31'b0, overrun}, {31'b0, e_ovr});
            check("pwm_left", {31'b0, pwm_left}, {31'b0, e_l});
            check("pwm_right", {31'b0, pwm_right}, {31'b0, e_r});
            check("atten_ready", {31'b0, sample_ready2}, {31'b0, q_l.size() < DEPTH});
            check("atten_pwm_left", {31'b0, pwm_left2}, {31'b0, e_l2});
            check("atten_pwm_right", {31'b0, pwm_right2}, {31'b0, e_r2});
            if (count_en) begin
                cnt_l += int'(pwm_left);
                cnt_r += int'(pwm_right);
                cnt_l2 += int'(pwm_left2);
                cnt_r2 += int'(pwm_right2);
            end
        end
        reset = rst;
        sample_valid = v;
        sample_left = l;
        sample_right = r;
        @(posedge clk_pixel);
        model_edge(rst, v, int'($signed(l)), int'($signed(r)));
        m_valid = 1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        step(1, 0, 16'h0, 16'h0);
        step(1, 0, 16'h0, 16'h0);
    endtask

    // Step until the model holds the given left sample; bounded.
    task automatic wait_pop(logic [15:0] tl);
        int n;
        n = 0;
        while (held_l != int'($signed(tl)) && n < 2 * PERIOD + 4) begin
            idle(1);
            n++;
        end
        check("pop_timeout", {31'b0, held_l == int'($signed(tl))}, 32'd1);
    endtask

    // Count highs over whole periods, aligned so every counted bit uses one duty.
    task automatic count_periods(int n);
        cnt_l = 0; cnt_r = 0; cnt_l2 = 0; cnt_r2 = 0;
        count_en = 1;
        idle(n * PERIOD);
        count_en = 0;
    endtask

    logic [15:0] burst_l[5];

    initial begin
        burst_l[0] = 16'h8000;
        burst_l[1] = 16'hC000;
        burst_l[2] = 16'h0000;
        burst_l[3] = 16'h4000;
        burst_l[4] = 16'h7F00;

        do_reset();
        #1;
        check("reset_ready", {31'b0, sample_ready}, 32'd1);
        check("reset_overrun", {31'b0, overrun}, 32'd0);
        check("reset_pwm", {30'b0, pwm_left, pwm_right}, 32'd0);

`ifndef AUDIO_PWM_SIGMA_DELTA_EN
        // Idle after reset: 50% duty.
        idle(1);
        count_periods(1);
        check("idle_left_highs", cnt_l, 128);
        check("idle_right_highs", cnt_r, 128);

        // Full-scale extremes.
        step(0, 1, 16'h7FFF, 16'h8000);
        wait_pop(16'h7FFF);
        idle(1);
        count_periods(1);
        check("max_left_highs", cnt_l, 255);
        check("min_right_highs", cnt_r, 0);

        // Hold with no further pushes; attenuated instance sees 0x7FF0 >>> 4.
        step(0, 1, 16'h0100, 16'h7FF0);
        wait_pop(16'h0100);
        idle(1);
        count_periods(3);
        check("hold_left_highs", cnt_l, 3 * 129);
        check("atten_right_highs", cnt_r2, 3 * 135);
        check("atten_left_highs", cnt_l2, 3 * 128);
`endif

        // Overflow: five back-to-back pairs into a depth-4 FIFO.
        do_reset();
        idle(10);
        for (int i = 0; i < 4; i++) step(0, 1, burst_l[i], 16'h0000);
        #1;
        check("ready_low_when_full", {31'b0, sample_ready}, 32'd0);
        step(0, 1, burst_l[4], 16'h0000);
        #1;
        check("overrun_set", {31'b0, overrun}, 32'd1);
        wait_pop(burst_l[0]);
        idle(1);
`ifndef AUDIO_PWM_SIGMA_DELTA_EN
        count_periods(1);
        check("burst0_highs", cnt_l, 0);
        count_periods(1);
        check("burst1_highs", cnt_l, 64);
        count_periods(1);
        check("burst2_highs", cnt_l, 128);
        count_periods(1);
        check("burst3_highs", cnt_l, 192);
        count_periods(1);
        check("burst_drop_highs", cnt_l, 192);
`else
        idle(5 * PERIOD);
`endif
        #1;
        check("overrun_sticky", {31'b0, overrun}, 32'd1);
        do_reset();
        #1;
        check("overrun_cleared", {31'b0, overrun}, 32'd0);

`ifdef AUDIO_PWM_SIGMA_DELTA_EN
        step(0, 1, 16'h4000, 16'h0000);
        wait_pop(16'h4000);
        idle(64);
        count_periods(4);
        check("sd_left_density", cnt_l, 768);
        check("sd_right_density", cnt_r, 512);
`endif

        // Randomized traffic with varying rates and occasional resets.
        for (int blk = 0; blk < 30; blk++) begin
            int rate;
            case ($urandom_range(0, 2))
                0: rate = 1;
                1: rate = 20;
                default: rate = 90;
            endcase
            for (int i = 0; i < 300; i++) begin
                bit rst, v;
                rst = ($urandom_range(0, 2999) == 0);
                v = ($urandom_range(0, 99) < rate);
                step(rst, v, 16'($urandom), 16'($urandom));
            end
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
